// File: rtl/axis_arb_pkg.sv
`default_nettype none
//==============================================================================
// Package     : axis_arb_pkg
// Description : Shared types, limits and the round-robin pick helper for the
//               packet-granular AXI4-Stream arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
package axis_arb_pkg;

    // Supported range of slave ports; the pick helper is sized for the maximum.
    localparam int c_MIN_PORTS = 2;
    localparam int c_MAX_PORTS = 8;
    localparam int c_MAX_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                   found;
        logic [c_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask, searching upward from (last+1) mod n_ports with wrap.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_PORTS-1:0] mask,
        input logic [c_MAX_IDX_W-1:0] last,
        input int                     n_ports
    );
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int i = 1; i <= c_MAX_PORTS; i++) begin
            if (i <= n_ports && !res.found) begin
                cand = (int'(last) + i) % n_ports;
                if (mask[3'(cand)]) begin
                    res.found = 1'b1;
                    res.idx   = 3'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
//==============================================================================
// Module      : axis_out_reg
// Description : One-entry AXI4-Stream register slice. Holds the whole beat
//               payload; supports load and drain in the same cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module axis_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 Aclk,
    input  logic                 Arst,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 m_tready_i,
    output logic                 m_tvalid_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q,   valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // Next state: a load wins over a drain; payload is held when not reloaded.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load_i) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end else if (valid_q && m_tready_i) begin
            valid_d   = 1'b0;
        end
    end

    // Register stage, cleared to zero on reset so in-flight data is discarded.
    always_ff @(posedge Aclk) begin
        if (Arst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign m_tvalid_o = valid_q;
    assign payload_o  = payload_q;

endmodule
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : axis_rr_arbiter
// Description : Packet-granular round-robin arbiter merging N_PORTS AXI4-Stream
//               slaves onto one registered master port. A grant lasts from the
//               first beat to the accepted TLAST beat; null beats are dropped.
// Revision    : 1.0 - initial release
//==============================================================================
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,   // valid range 2..8
    parameter int DATA_BYTES = 2,
    parameter int ID_W       = 4,
    parameter int DEST_W     = 4
) (
    input  logic                           Aclk,
    input  logic                           Arst,
    input  logic [N_PORTS-1:0]             port_en,
    input  logic [N_PORTS-1:0]             s_tvalid,
    output logic [N_PORTS-1:0]             s_tready,
    input  logic [N_PORTS*8*DATA_BYTES-1:0] s_tdata,
    input  logic [N_PORTS*DATA_BYTES-1:0]  s_tstrb,
    input  logic [N_PORTS*DATA_BYTES-1:0]  s_tkeep,
    input  logic [N_PORTS-1:0]             s_tlast,
    input  logic [N_PORTS*ID_W-1:0]        s_tid,
    input  logic [N_PORTS*DEST_W-1:0]      s_tdest,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [8*DATA_BYTES-1:0]        m_tdata,
    output logic [DATA_BYTES-1:0]          m_tstrb,
    output logic [DATA_BYTES-1:0]          m_tkeep,
    output logic                           m_tlast,
    output logic [ID_W-1:0]                m_tid,
    output logic [DEST_W-1:0]              m_tdest,
    output logic [N_PORTS-1:0]             grant_o,
    output logic                           busy_o
);

    localparam int c_TDATA_W   = 8 * DATA_BYTES;
    localparam int c_IDX_W     = $clog2(N_PORTS);
    localparam int c_PAYLOAD_W = c_TDATA_W + 2 * DATA_BYTES + 1 + ID_W + DEST_W;

    arb_state_e           state_q, state_d;
    logic [c_IDX_W-1:0]   gnt_q, gnt_d;
    logic [c_IDX_W-1:0]   last_q, last_d;

    logic [c_PAYLOAD_W-1:0] w_port_payload [N_PORTS];
    logic [c_PAYLOAD_W-1:0] w_sel_payload;
    logic [c_PAYLOAD_W-1:0] w_out_payload;
    logic [c_MAX_PORTS-1:0] w_cand;
    rr_pick_t               w_pick;
    logic [N_PORTS-1:0]     w_gnt_onehot;
    logic [DATA_BYTES-1:0]  w_sel_keep;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_up_ready;
    logic                   w_granted;
    logic                   w_accept;
    logic                   w_load;

    // Pack each slave's sideband into one payload word so a single mux selects it.
    generate
        for (genvar p = 0; p < N_PORTS; p++) begin : g_port
            assign w_port_payload[p] = {s_tdata[p*c_TDATA_W +: c_TDATA_W],
                                        s_tstrb[p*DATA_BYTES +: DATA_BYTES],
                                        s_tkeep[p*DATA_BYTES +: DATA_BYTES],
                                        s_tlast[p],
                                        s_tid[p*ID_W +: ID_W],
                                        s_tdest[p*DEST_W +: DEST_W]};
        end
    endgenerate

    assign w_sel_payload = w_port_payload[gnt_q];
    assign w_sel_keep    = s_tkeep[gnt_q*DATA_BYTES +: DATA_BYTES];
    assign w_sel_valid   = s_tvalid[gnt_q];
    assign w_sel_last    = s_tlast[gnt_q];

    assign w_cand = c_MAX_PORTS'(s_tvalid & port_en);
    assign w_pick = rr_pick(w_cand, c_MAX_IDX_W'(last_q), N_PORTS);

    assign w_granted    = (state_q == GRANT);
    assign w_gnt_onehot = N_PORTS'(1) << gnt_q;
    // Ready never looks at s_tvalid: only the grant and output-stage space.
    assign w_up_ready   = !m_tvalid || m_tready;
    assign w_accept     = w_granted && w_sel_valid && w_up_ready;
    // Null beats (no kept bytes, not last) are consumed without being forwarded.
    assign w_load       = w_accept && ((|w_sel_keep) || w_sel_last);

    assign s_tready = (w_granted && w_up_ready) ? w_gnt_onehot : '0;
    assign grant_o  = w_granted ? w_gnt_onehot : '0;
    assign busy_o   = w_granted || m_tvalid;

    // Next-state logic: arbitrate in IDLE, hold the grant until TLAST is accepted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (w_pick.found) begin
                    state_d = GRANT;
                    gnt_d   = c_IDX_W'(w_pick.idx);
                    last_d  = c_IDX_W'(w_pick.idx);
                end
            end
            GRANT: begin
                if (w_accept && w_sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers; last_grant resets so port 0 wins first.
    always_ff @(posedge Aclk) begin
        if (Arst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= c_IDX_W'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    axis_out_reg #(
        .PAYLOAD_W (c_PAYLOAD_W)
    ) u_out_reg (
        .Aclk       (Aclk),
        .Arst       (Arst),
        .load_i     (w_load),
        .payload_i  (w_sel_payload),
        .m_tready_i (m_tready),
        .m_tvalid_o (m_tvalid),
        .payload_o  (w_out_payload)
    );

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest} = w_out_payload;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_axis_rr_arbiter
// Description : Self-checking bench for axis_rr_arbiter: directed scenarios
//               plus randomized traffic against a transfer-level reference.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axis_rr_arbiter;

    localparam int N   = 4;
    localparam int DB  = 2;
    localparam int IDW = 4;
    localparam int DSW = 4;
    localparam int TW  = 8 * DB;

    typedef struct packed {
        logic [TW-1:0]  data;
        logic [DB-1:0]  strb;
        logic [DB-1:0]  keep;
        logic           last;
        logic [IDW-1:0] id;
        logic [DSW-1:0] dest;
    } beat_t;

    logic              Aclk = 1'b0;
    logic              Arst = 1'b1;
    logic [N-1:0]      port_en = '1;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [N*TW-1:0]   s_tdata;
    logic [N*DB-1:0]   s_tstrb, s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N*IDW-1:0]  s_tid;
    logic [N*DSW-1:0]  s_tdest;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [TW-1:0]     m_tdata;
    logic [DB-1:0]     m_tstrb, m_tkeep;
    logic              m_tlast;
    logic [IDW-1:0]    m_tid;
    logic [DSW-1:0]    m_tdest;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    beat_t drv [N];

    always #5 Aclk = ~Aclk;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            s_tdata[p*TW +: TW]   = drv[p].data;
            s_tstrb[p*DB +: DB]   = drv[p].strb;
            s_tkeep[p*DB +: DB]   = drv[p].keep;
            s_tlast[p]            = drv[p].last;
            s_tid[p*IDW +: IDW]   = drv[p].id;
            s_tdest[p*DSW +: DSW] = drv[p].dest;
        end
    end

    axis_rr_arbiter #(.N_PORTS(N), .DATA_BYTES(DB), .ID_W(IDW), .DEST_W(DSW)) dut (
        .Aclk(Aclk), .Arst(Arst), .port_en(port_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Bench state
    int           n_cmp = 0;
    int           n_mis = 0;
    int           vprob = 100;
    int           rprob = 100;
    logic         rst_req = 1'b1;
    logic [N-1:0] en_next = '1;
    logic [N-1:0] hs_s = '0;
    logic [N-1:0] prev_gr = '0;
    beat_t        srcq [N][$];
    beat_t        expq [N][$];
    int           glog [$];

    // Reference: who owns the link, round-robin pointer, output holding register
    logic  r_busy = 1'b0;
    int    r_gnt  = 0;
    int    r_last = N - 1;
    logic  r_ov   = 1'b0;
    beat_t r_ob   = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int p, input logic [TW-1:0] d, input logic [DB-1:0] k,
                             input logic l, input logic [DSW-1:0] dst);
        beat_t b;
        b.data = d; b.strb = DB'($urandom); b.keep = k; b.last = l;
        b.id = IDW'(p); b.dest = dst;
        srcq[p].push_back(b);
        if (k != 0 || l) expq[p].push_back(b);
    endtask

    task automatic push_rand_pkt(input int p);
        int             len;
        logic [DSW-1:0] dst;
        len = $urandom_range(1, 4);
        dst = DSW'($urandom);
        for (int i = 0; i < len; i++)
            push_beat(p, TW'($urandom), ($urandom_range(0, 4) == 0) ? '0 : DB'($urandom_range(1, 3)),
                      (i == len - 1), dst);
    endtask

    function automatic int glog_at(input int i);
        return (glog.size() > i) ? glog[i] : -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < N; p++) s += srcq[p].size() + expq[p].size();
        return s;
    endfunction

    // Outputs vs reference, scoreboard, then advance the reference past the next edge.
    task automatic check_and_step();
        logic [N-1:0] exp_gr, cand;
        logic         up, acc;
        beat_t        b, e;
        int           pid;
        logic         avail;
        exp_gr = r_busy ? (N'(1) << r_gnt) : '0;
        up     = !r_ov || m_tready;
        chk("grant_o",  64'(grant_o),  64'(exp_gr));
        chk("s_tready", 64'(s_tready), 64'((r_busy && up) ? exp_gr : '0));
        chk("busy_o",   64'(busy_o),   64'(r_busy || r_ov));
        chk("m_tvalid", 64'(m_tvalid), 64'(r_ov));
        chk("m_fields", 64'({m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest}), 64'(r_ob));
        if (grant_o != 0 && prev_gr == 0)
            for (int k = 0; k < N; k++) if (grant_o[k]) glog.push_back(k);
        prev_gr = grant_o;
        if (!Arst && m_tvalid && m_tready) begin
            pid   = int'(m_tid);
            avail = (pid < N) && (expq[pid].size() > 0);
            chk("sb_avail", 64'(avail), 64'(1));
            if (avail) begin
                e = expq[pid].pop_front();
                chk("sb_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tdest}),
                               64'({e.data, e.keep, e.last, e.dest}));
            end
        end
        if (Arst) begin
            r_busy = 1'b0; r_last = N - 1; r_ov = 1'b0; r_ob = '0;
        end else begin
            b   = drv[r_gnt];
            acc = r_busy && s_tvalid[r_gnt] && up;
            if (acc && (b.keep != 0 || b.last)) begin
                r_ov = 1'b1; r_ob = b;
            end else if (r_ov && m_tready) begin
                r_ov = 1'b0;
            end
            if (r_busy) begin
                if (acc && b.last) r_busy = 1'b0;
            end else begin
                cand = s_tvalid & port_en;
                for (int k = 1; k <= N; k++) begin
                    if (!r_busy && cand[(r_last + k) % N]) begin
                        r_busy = 1'b1;
                        r_gnt  = (r_last + k) % N;
                        r_last = r_gnt;
                    end
                end
            end
        end
        hs_s = s_tvalid & s_tready;
    endtask

    // One clock: drive just after the rising edge, check on the falling edge.
    task automatic cycle();
        logic [63:0] junk;
        @(posedge Aclk);
        #1;
        for (int p = 0; p < N; p++) if (hs_s[p] && srcq[p].size() > 0) srcq[p].delete(0);
        Arst    = rst_req;
        rst_req = 1'b0;
        port_en = en_next;
        if (Arst) for (int p = 0; p < N; p++) begin srcq[p].delete(); expq[p].delete(); end
        for (int p = 0; p < N; p++) begin
            if (!Arst && s_tvalid[p] && !hs_s[p]) begin
                s_tvalid[p] = 1'b1;
            end else if (!Arst && srcq[p].size() > 0 && $urandom_range(0, 99) < vprob) begin
                s_tvalid[p] = 1'b1;
                drv[p]      = srcq[p][0];
            end else begin
                s_tvalid[p] = 1'b0;
                junk        = {$urandom, $urandom};
                drv[p]      = junk[$bits(beat_t)-1:0];
            end
        end
        m_tready = ($urandom_range(0, 99) < rprob);
        @(negedge Aclk);
        check_and_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        cycle();
        glog.delete();
    endtask

    initial begin
        logic done;
        for (int p = 0; p < N; p++) drv[p] = '0;

        // Reset state, then a single 3-beat packet on port 0
        do_reset();
        push_beat(0, 16'h1111, 2'b11, 1'b0, 4'h5);
        push_beat(0, 16'h2222, 2'b11, 1'b0, 4'h5);
        push_beat(0, 16'h3333, 2'b11, 1'b1, 4'h5);
        run(8);
        chk("t1_first_grant", 64'(glog_at(0)), 64'(0));

        // All ports busy with 2-beat packets: rotation 0,1,2,3,0
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) begin
                push_beat(p, TW'($urandom), 2'b11, 1'b0, 4'(p));
                push_beat(p, TW'($urandom), 2'b01, 1'b1, 4'(p));
            end
        run(30);
        for (int i = 0; i < 5; i++) chk("t2_rr_order", 64'(glog_at(i)), 64'(i % N));

        // Port 1 stalled by m_tready low for 3 cycles mid-packet
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(1, 16'hA000 + TW'(i), 2'b11, (i == 3), 4'h1);
        run(3);
        rprob = 0;
        run(3);
        rprob = 100;
        run(6);

        // Null beat on port 2 is dropped; keep=0 with TLAST is forwarded
        do_reset();
        push_beat(2, 16'hAAAA, 2'b11, 1'b0, 4'h2);
        push_beat(2, 16'h5555, 2'b00, 1'b0, 4'h2);
        push_beat(2, 16'hBBBB, 2'b11, 1'b1, 4'h2);
        push_beat(2, 16'hCCCC, 2'b00, 1'b1, 4'h2);
        run(12);

        // Port enable mask: port 2 masked, port 3 wins; clearing port 3 mid-packet
        en_next = 4'b1011;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_beat(2, TW'($urandom), 2'b11, (i == 2), 4'h2);
            push_beat(3, TW'($urandom), 2'b11, (i == 2), 4'h3);
        end
        run(2);
        en_next = 4'b0011;
        run(10);
        chk("t5_masked_grant", 64'(glog_at(0)), 64'(3));
        en_next = 4'b1111;
        run(8);
        chk("t5_reenabled", 64'(glog_at(1)), 64'(2));

        // Reset on beat 2 of 4 truncates the packet; port 0 wins after release
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(2, TW'($urandom), 2'b11, (i == 3), 4'h7);
        run(2);
        rst_req = 1'b1;
        cycle();
        cycle();
        chk("t6_mvalid", 64'(m_tvalid), 64'(0));
        chk("t6_grant",  64'(grant_o),  64'(0));
        glog.delete();
        for (int p = 0; p < N; p++) push_rand_pkt(p);
        run(20);
        chk("t6_first_grant", 64'(glog_at(0)), 64'(0));

        // Randomized traffic
        vprob = 70;
        rprob = 70;
        for (int c = 0; c < 4000 && n_mis < 30; c++) begin
            for (int p = 0; p < N; p++) if (srcq[p].size() < 3) push_rand_pkt(p);
            if ($urandom_range(0, 49) == 0) en_next = N'($urandom) | (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 599) == 0) rst_req = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                vprob = $urandom_range(30, 100);
                rprob = $urandom_range(20, 100);
            end
            cycle();
        end

        // Drain everything still queued
        en_next = '1;
        vprob   = 100;
        rprob   = 100;
        done    = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            cycle();
            done = (pending() == 0) && !r_busy && !r_ov;
        end
        chk("drain_done", 64'(done), 64'(1));
        chk("sb_left", 64'(pending()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI4-Stream master port between N_PORTS AXI4-Stream slave ports. A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved on the shared link. The block sits upstream of the TID/TDEST-sorting stream sink and feeds it one merged stream with TID/TDEST preserved. A single registered output stage drives the master side.

## Interface
Parameters:
- N_PORTS, 4, number of slave ports (2..8)
- DATA_BYTES, 2, bytes per beat; TDATA width = 8*DATA_BYTES
- ID_W, 4, TID width
- DEST_W, 4, TDEST width

Ports:
- Aclk  in  1  clock, all logic on rising edge
- Arst  in  1  reset, synchronous, active-high
- port_en  in  N_PORTS  per-port enable mask for new grants
- s_tvalid  in  N_PORTS  per-port TVALID
- s_tready  out  N_PORTS  per-port TREADY
- s_tdata  in  N_PORTS*8*DATA_BYTES  port p in slice p
- s_tstrb, s_tkeep  in  N_PORTS*DATA_BYTES  port p in slice p
- s_tlast  in  N_PORTS  per-port TLAST
- s_tid  in  N_PORTS*ID_W;  s_tdest  in  N_PORTS*DEST_W
- m_tvalid  out  1;  m_tready  in  1
- m_tdata  out  8*DATA_BYTES;  m_tstrb, m_tkeep  out  DATA_BYTES
- m_tlast  out  1;  m_tid  out  ID_W;  m_tdest  out  DEST_W
- grant_o  out  N_PORTS  one-hot current grant, 0 in IDLE
- busy_o  out  1  high in GRANT or while m_tvalid high

## Operation
- FSM states: IDLE, GRANT.
- IDLE: candidates = s_tvalid & port_en. Pick the first candidate searching from (last_grant+1) mod N_PORTS upward with wrap. If any candidate exists, register gnt and last_grant, then go to GRANT. Otherwise stay in IDLE.
- GRANT: s_tready[gnt] = !m_tvalid || m_tready. All other s_tready bits are 0. Every s_tready bit is 0 in IDLE.
- Accepted beat on gnt:
  - If tkeep != 0, or tlast = 1: load the output register with tdata/tstrb/tkeep/tlast/tid/tdest and set m_tvalid.
  - If tkeep == 0 and tlast = 0: the beat is a null beat. Consume it and do not forward it.
- Accepted beat with tlast = 1: go to IDLE at the same edge.
- Output register: m_tvalid clears on a master handshake unless it is reloaded at the same edge. Simultaneous load and drain in one cycle is required.
- Deasserting port_en mid-packet does not abort the packet. It only blocks future grants.
- Reset values: state IDLE, last_grant = N_PORTS-1 (port 0 wins first), s_tready 0, grant_o 0, busy_o 0, m_tvalid 0, all m_* data/side fields 0.
- Arst mid-packet: the packet is truncated with no TLAST emitted, and the output register is discarded.

## Timing
- Arbitration latency: a request seen in IDLE at edge k gives GRANT at k; the first s_tready is high in cycle k+1.
- Input-to-output latency: a beat accepted at edge k is visible on m_* after edge k; m_tvalid is high in cycle k+1.
- Throughput inside a packet: 1 beat/cycle while m_tready = 1.
- Packet gap: exactly one IDLE cycle (no s_tready) between the TLAST acceptance and the next packet's first s_tready.
- m_* fields are held stable while m_tvalid = 1 and m_tready = 0, per AXI4-Stream.
- s_tvalid is not used combinationally to drive s_tready. s_tready depends only on state, gnt, m_tvalid and m_tready.

## Structure
- Package axis_arb_pkg holds:
  - state enum (IDLE, GRANT)
  - round-robin pick function (mask, last_grant) returning index and found flag
  - localparam limits for N_PORTS
- Sub-module axis_out_reg: one-entry AXI4-Stream register slice. It has load/drain logic, holds all m_* fields and is reset to zero.
- The top level holds the FSM, gnt/last_grant registers and input slice muxing.

## Test plan
- Single port 0, 3-beat packet 0x1111/0x2222/0x3333 with TLAST on beat 3 and m_tready = 1 -> m_tdata shows the same sequence in consecutive cycles, m_tlast on 0x3333, m_tid/m_tdest equal the inputs, grant_o = 0001.
- All 4 ports request continuously with 2-beat packets -> grant order 0,1,2,3,0; exactly one idle s_tready cycle between packets; no interleaving.
- Port 1 mid-packet, m_tready low for 3 cycles -> m_* held stable, s_tready[1] = 0 while stalled, no beat lost or duplicated.
- Port 2 beat with tkeep = 00, tlast = 0, between two tkeep = 11 beats -> the null beat is consumed and two beats are forwarded. A beat with tkeep = 00, tlast = 1 is forwarded with m_tlast = 1.
- port_en = 1011 with ports 2 and 3 requesting -> port 3 granted. Clearing port_en[3] mid-packet -> the packet completes.
- Arst asserted on beat 2 of 4 -> next cycle m_tvalid = 0, grant_o = 0, and the first grant after release goes to port 0.
